// File: rtl/tile_fetch_arbiter.sv
// tile_fetch_arbiter
// Shares one single-port tile memory (1-cycle read latency) between the
// VGA scanout, which fetches one tile row per line, and a host writer on a
// valid/ready port. The display always has priority. A display request that
// arrives during a host write is deferred by one slot. A request that arrives
// while a display fetch is still busy is dropped and counted.
// Optional feature: define TILE_ARB_DBUF_EN for double buffering. The display
// reads the front bank, the host writes the back bank, and the banks swap on
// vsync_i after a swap_req.
module tile_fetch_arbiter #(
    parameter int DATA_W = 64,
    parameter int ROW_W  = 5,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              disp_req,
    input  logic [ROW_W-1:0]  disp_row,
    output logic [DATA_W-1:0] line_data,
    output logic              line_valid,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ROW_W-1:0]  wr_row,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              vsync_i,
    input  logic              swap_req,
    output logic              swap_done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ROW_W:0]    mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  overrun_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        DISP_RD,
        DISP_CAP,
        HOST_WR
    } state_t;

    state_t             state;
    logic               disp_pend;
    logic [ROW_W-1:0]   pend_row;
    logic               init_done;
    logic               front;
    logic               back;
    logic               disp_busy;

    // A display fetch is outstanding from acceptance until its capture cycle.
    assign disp_busy = (state == DISP_RD) || (state == DISP_CAP) || disp_pend;

    // The host may only be accepted in an idle slot that no display request claims.
    assign wr_ready = init_done && (state == IDLE) && !disp_req && !disp_pend;

`ifdef TILE_ARB_DBUF_EN
    logic swap_pend;

    assign back = ~front;

    // Bank swap bookkeeping: arm on swap_req, take effect on the next vsync_i.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            front     <= 1'b0;
            swap_pend <= 1'b0;
            swap_done <= 1'b0;
        end else begin
            swap_done <= 1'b0;
            if (vsync_i && swap_pend) begin
                front     <= ~front;
                swap_pend <= 1'b0;
                swap_done <= 1'b1;
            end else if (swap_req) begin
                swap_pend <= 1'b1;
            end
        end
    end
`else
    logic unused_swap;

    assign front       = 1'b0;
    assign back        = 1'b0;
    assign swap_done   = 1'b0;
    assign unused_swap = swap_req ^ vsync_i;
`endif

    // Arbitration FSM with registered memory strobes, line register and overrun counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            disp_pend   <= 1'b0;
            pend_row    <= '0;
            init_done   <= 1'b0;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            line_data   <= '0;
            line_valid  <= 1'b0;
            overrun_cnt <= '0;
        end else begin
            init_done  <= 1'b1;
            line_valid <= 1'b0;

            if (disp_req && disp_busy && (overrun_cnt != '1)) begin
                overrun_cnt <= overrun_cnt + CNT_W'(1);
            end

            case (state)
                IDLE: begin
                    if (disp_req || disp_pend) begin
                        state     <= DISP_RD;
                        mem_en    <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= {front, (disp_pend ? pend_row : disp_row)};
                        disp_pend <= 1'b0;
                    end else if (wr_valid && wr_ready) begin
                        state     <= HOST_WR;
                        mem_en    <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= {back, wr_row};
                        mem_wdata <= wr_data;
                    end
                end
                DISP_RD: begin
                    state  <= DISP_CAP;
                    mem_en <= 1'b0;
                end
                DISP_CAP: begin
                    state      <= IDLE;
                    line_data  <= mem_rdata;
                    line_valid <= 1'b1;
                end
                HOST_WR: begin
                    state  <= IDLE;
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    if (disp_req) begin
                        disp_pend <= 1'b1;
                        pend_row  <= disp_row;
                    end
                end
                default: begin
                    state  <= IDLE;
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                end
            endcase
        end
    end

endmodule
